window3x3_linebuf: RTL and testbench



---
 rtl/window3x3_linebuf.sv | 116 +++++++++++
 tb/tb_window3x3_linebuf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/window3x3_linebuf.sv
// window3x3_linebuf: streaming 3x3 neighbourhood generator.
// Two row line buffers plus a 3x3 shift window produce one window per
// accepted interior pixel, one cycle after the pixel is accepted.
module window3x3_linebuf #(
    parameter int PIXEL_W    = 8,
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int XW         = $clog2(IMG_WIDTH),
    parameter int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIXEL_W-1:0]   pixel_in,
    input  logic                 valid_in,
    output logic [9*PIXEL_W-1:0] win_out,
    output logic                 win_valid,
    output logic [XW-1:0]        center_x,
    output logic [YW-1:0]        center_y,
    output logic                 frame_done
);

    logic [XW-1:0]      col;
    logic [YW-1:0]      row;
    logic               col_last;
    logic               row_last;
    logic               accept;

    logic [PIXEL_W-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_W-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_W-1:0] top_px;
    logic [PIXEL_W-1:0] mid_px;

    logic [PIXEL_W-1:0] win [3][3];

    assign accept   = valid_in && !rst;
    assign col_last = (col == XW'(IMG_WIDTH - 1));
    assign row_last = (row == YW'(IMG_HEIGHT - 1));

    // Old contents at the current column form the upper two rows of the new column vector.
    assign top_px = lb1[col];
    assign mid_px = lb0[col];

    // Raster position of the next pixel to be accepted; wraps per row and per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                end else begin
                    row <= row + YW'(1);
                end
            end else begin
                col <= col + XW'(1);
            end
        end
    end

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2; contents are left uncleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pixel_in;
        end
    end

    // Window rows shift left and take the new column vector at the right-hand side.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (valid_in) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= top_px;
            win[1][2] <= mid_px;
            win[2][2] <= pixel_in;
        end
    end

    // Window flags and centre coordinates; border positions never raise win_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            center_x   <= '0;
            center_y   <= '0;
        end else begin
            win_valid  <= valid_in && (col >= XW'(2)) && (row >= YW'(2));
            frame_done <= valid_in && col_last && row_last;
            if (valid_in) begin
                center_x <= col - XW'(1);
                center_y <= row - YW'(1);
            end
        end
    end

    // Flatten the window so element 3*i+j sits at bits [k*PIXEL_W +: PIXEL_W].
    always_comb begin
        win_out = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_out[(3*i+j)*PIXEL_W +: PIXEL_W] = win[i][j];
            end
        end
    end

endmodule

// File: tb/tb_window3x3_linebuf.sv
// tb_window3x3_linebuf: randomized self-checking bench for window3x3_linebuf.
// A frame-image array records every accepted pixel; expected windows are
// read straight out of that image by raster coordinate.
module tb_window3x3_linebuf;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic            clk = 1'b0;
    logic            rst;
    logic [PW-1:0]   pixel_in;
    logic            valid_in;
    logic [9*PW-1:0] win_out;
    logic            win_valid;
    logic [XW-1:0]   center_x;
    logic [YW-1:0]   center_y;
    logic            frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [PW-1:0] img [H][W];
    int  mc = 0;
    int  mr = 0;
    int  frame_wins = 0;
    bit  ramp_mode = 1'b0;
    int  ramp_base = 0;

    window3x3_linebuf #(
        .PIXEL_W   (PW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .win_out   (win_out),
        .win_valid (win_valid),
        .center_x  (center_x),
        .center_y  (center_y),
        .frame_done(frame_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference window of the 8-wide ramp image, taken from its known pixel values.
    function automatic logic [9*PW-1:0] packRamp(input int base, input bit last);
        int first_v [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        int last_v  [9] = '{29, 30, 31, 37, 38, 39, 45, 46, 47};
        logic [9*PW-1:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) begin
            p[k*PW +: PW] = PW'(base + (last ? last_v[k] : first_v[k]));
        end
        return p;
    endfunction

    task automatic applyStimulus(input logic [PW-1:0] pix, input logic vld);
        logic [9*PW-1:0] exp_win;
        logic            exp_v;
        logic            exp_fd;
        int              ec;
        int              er;
        @(negedge clk);
        rst      = 1'b0;
        pixel_in = pix;
        valid_in = vld;
        exp_v    = 1'b0;
        exp_fd   = 1'b0;
        exp_win  = '0;
        ec       = 0;
        er       = 0;
        if (vld) begin
            img[mr][mc] = pix;
            if (mc >= 2 && mr >= 2) begin
                exp_v = 1'b1;
                ec    = mc - 1;
                er    = mr - 1;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        exp_win[(3*i+j)*PW +: PW] = img[mr-2+i][mc-2+j];
                    end
                end
            end
            exp_fd = (mc == W-1) && (mr == H-1);
        end
        @(posedge clk);
        #1;
        checkOutput("win_valid", win_valid, exp_v);
        checkOutput("frame_done", frame_done, exp_fd);
        if (win_valid) frame_wins++;
        if (exp_v) begin
            checkOutput("win_out", win_out, exp_win);
            checkOutput("center_x", center_x, ec);
            checkOutput("center_y", center_y, er);
            if (ramp_mode && ec == 1 && er == 1)
                checkOutput("ramp_first", win_out, packRamp(ramp_base, 1'b0));
            if (ramp_mode && ec == W-2 && er == H-2)
                checkOutput("ramp_last", win_out, packRamp(ramp_base, 1'b1));
        end
        if (vld) begin
            if (mc == W-1 && mr == H-1) begin
                checkOutput("win_count", frame_wins, (W-2)*(H-2));
                frame_wins = 0;
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    // Reset with valid_in high to confirm reset wins; every output must read zero.
    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b1;
        pixel_in = PW'($urandom);
        @(posedge clk);
        #1;
        checkOutput("rst_win_valid", win_valid, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_center_x", center_x, 0);
        checkOutput("rst_center_y", center_y, 0);
        checkOutput("rst_win_out", win_out, 0);
        mc = 0;
        mr = 0;
        frame_wins = 0;
    endtask

    task automatic runFrame(input int base, input bit rnd, input int maxgap, input int stop_after);
        logic [PW-1:0] pix;
        int gaps;
        ramp_mode = !rnd;
        ramp_base = base;
        for (int n = 0; n < W*H; n++) begin
            if (stop_after >= 0 && n == stop_after) return;
            gaps = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (gaps) applyStimulus(PW'($urandom), 1'b0);
            pix = rnd ? PW'($urandom) : PW'(base + W*mr + mc);
            applyStimulus(pix, 1'b1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        pixel_in = '0;
        repeat (2) @(posedge clk);
        doReset();
        runFrame(0, 1'b0, 0, -1);
        runFrame(0, 1'b0, 5, -1);
        runFrame(0, 1'b0, 0, -1);
        runFrame(100, 1'b0, 0, -1);
        runFrame(0, 1'b0, 0, 20);
        doReset();
        runFrame(0, 1'b0, 0, -1);
        runFrame(0, 1'b1, 3, -1);
        runFrame(0, 1'b1, 0, -1);
        runFrame(0, 1'b1, 0, -1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
